// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
//   Shared definitions for the weighted round-robin arbiter stages
//   (next_grant_precompute and GRANT) and their testbenches.
//
//   Contents:
//     CHANNELS, WIDTH, DEFAULT_WEIGHT, WEIGHTLIMIT  default parameter values
//     IDX_W                                         channel index width
//     idx_width()                                   index width helper, min 1
//     grant_state_t                                 GRANT stage state encoding
// ---------------------------------------------------------------------------
package rr_arb_pkg;

    localparam int CHANNELS       = 8;
    localparam int WIDTH          = 32;
    localparam int DEFAULT_WEIGHT = 1;
    localparam int WEIGHTLIMIT    = 255;

    // Index width, never below one bit so a degenerate channel count still
    // yields a legal vector declaration.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(CHANNELS);

    typedef enum logic [1:0] {
        RESET         = 2'd0,
        GRANT_PROCESS = 2'd1,
        COUNT         = 2'd2,
        GETWEIGHT     = 2'd3
    } grant_state_t;

endpackage : rr_arb_pkg

// File: rtl/rr_priority_search.sv
// ---------------------------------------------------------------------------
// rr_priority_search
//   Combinational rotate-and-find-first. Returns the one-hot of the first set
//   bit of `eligible` when scanning ptr, ptr+1, ..., CHANNELS-1, 0, ...,
//   ptr-1. Returns zero when nothing is eligible.
//
//   Ports:
//     eligible  in  CHANNELS  channels that may be granted
//     ptr       in  IW        highest-priority channel index
//     onehot    out CHANNELS  one-hot winner, or zero
// ---------------------------------------------------------------------------
module rr_priority_search
    import rr_arb_pkg::*;
#(
    parameter int CHANNELS = rr_arb_pkg::CHANNELS,
    localparam int IW      = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] eligible,
    input  logic [IW-1:0]       ptr,
    output logic [CHANNELS-1:0] onehot
);

    int   sel_idx;
    int   scan_idx;
    logic found;

    // Scan offsets from the farthest to the nearest so the nearest eligible
    // channel (smallest offset from ptr) is the last one written, i.e. wins.
    always_comb begin
        sel_idx  = 0;
        scan_idx = 0;
        found    = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= CHANNELS) begin
                scan_idx = scan_idx - CHANNELS;
            end
            if (eligible[scan_idx]) begin
                sel_idx = scan_idx;
                found   = 1'b1;
            end
        end
        onehot = '0;
        if (found) begin
            onehot[sel_idx] = 1'b1;
        end
    end

endmodule : rr_priority_search

// File: rtl/next_grant_precompute.sv
// ---------------------------------------------------------------------------
// next_grant_precompute
//   Upstream companion of the GRANT stage. Keeps the per-channel weight
//   table and the rotating priority pointer, registers the next round-robin
//   candidate, and muxes out the weight of the channel currently granted.
//
//   Ports:
//     clk        in   1         system clock
//     reset      in   1         asynchronous active-high reset
//     request    in   CHANNELS  raw request vector (shared with GRANT)
//     grant      in   CHANNELS  grant fed back from GRANT (one-hot or zero)
//     cfg_wr_en  in   1         weight table write strobe
//     cfg_addr   in   IW        table index for write and read-back
//     cfg_wdata  in   WIDTH     weight to write
//     cfg_rdata  out  WIDTH     registered read-back of table[cfg_addr]
//     nextGrant  out  CHANNELS  registered one-hot next candidate, or zero
//     weight     out  WIDTH     weight of the granted channel, combinational
// ---------------------------------------------------------------------------
module next_grant_precompute
    import rr_arb_pkg::*;
#(
    parameter int CHANNELS       = rr_arb_pkg::CHANNELS,
    parameter int WIDTH          = rr_arb_pkg::WIDTH,
    parameter int DEFAULT_WEIGHT = rr_arb_pkg::DEFAULT_WEIGHT,
    localparam int IW            = idx_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] request,
    input  logic [CHANNELS-1:0] grant,
    input  logic                cfg_wr_en,
    input  logic [IW-1:0]       cfg_addr,
    input  logic [WIDTH-1:0]    cfg_wdata,
    output logic [WIDTH-1:0]    cfg_rdata,
    output logic [CHANNELS-1:0] nextGrant,
    output logic [WIDTH-1:0]    weight
);

    // The table resets to a non-zero default, so it lives in flops rather
    // than block RAM.
    logic [WIDTH-1:0]    weight_table_reg [CHANNELS];
    logic [CHANNELS-1:0] eligible;
    logic [CHANNELS-1:0] search_onehot;
    logic [CHANNELS-1:0] next_grant_reg;
    logic [IW-1:0]       ptr_reg;
    logic [IW-1:0]       ptr_next;
    logic [IW-1:0]       grant_idx;
    logic                grant_any;
    logic                addr_in_range;
    logic [WIDTH-1:0]    cfg_rdata_reg;
    logic [WIDTH-1:0]    cfg_rdata_next;

    // Only matters when CHANNELS is not a power of two.
    assign addr_in_range = (32'(cfg_addr) < 32'(CHANNELS));

    // Per-entry table storage and eligibility. A zero weight masks the
    // channel out of the search. The search sees the pre-write value on the
    // cycle of a write because the entry only updates on the clock edge.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_entry
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                weight_table_reg[gi] <= WIDTH'(DEFAULT_WEIGHT);
            end else if (cfg_wr_en && addr_in_range && (cfg_addr == IW'(gi))) begin
                weight_table_reg[gi] <= cfg_wdata;
            end
        end

        assign eligible[gi] = request[gi] & (weight_table_reg[gi] != '0);
    end

    // Lowest set bit of grant; a multi-hot grant resolves to its lowest bit.
    always_comb begin
        grant_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (grant[i]) begin
                grant_idx = IW'(i);
            end
        end
    end

    assign grant_any = |grant;

    // Priority moves to the channel after the granted one. A grant held
    // across several cycles keeps rewriting the same pointer value.
    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            if (32'(grant_idx) == 32'(CHANNELS - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + IW'(1);
            end
        end
    end

    always_comb begin
        cfg_rdata_next = '0;
        if (addr_in_range) begin
            cfg_rdata_next = weight_table_reg[cfg_addr];
        end
    end

    rr_priority_search #(
        .CHANNELS (CHANNELS)
    ) u_search (
        .eligible (eligible),
        .ptr      (ptr_reg),
        .onehot   (search_onehot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg        <= '0;
            next_grant_reg <= '0;
            cfg_rdata_reg  <= '0;
        end else begin
            ptr_reg        <= ptr_next;
            next_grant_reg <= search_onehot;
            cfg_rdata_reg  <= cfg_rdata_next;
        end
    end

    // Unregistered on purpose: GRANT samples this one cycle after `grant`
    // changes, so a register here would hand it a stale weight.
    assign weight    = grant_any ? weight_table_reg[grant_idx] : '0;

    assign nextGrant = next_grant_reg;
    assign cfg_rdata = cfg_rdata_reg;

endmodule : next_grant_precompute

// File: tb/tb_next_grant_precompute.sv
// ---------------------------------------------------------------------------
// tb_next_grant_precompute
//   Directed self-checking bench for next_grant_precompute with default
//   parameters (8 channels, 32-bit weights, default weight 1). Expected
//   registered outputs are queued when a step is driven and popped after
//   the following clock edge.
// ---------------------------------------------------------------------------
module tb_next_grant_precompute;

    localparam int CH = 8;
    localparam int W  = 32;
    localparam int DW = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] request;
    logic [CH-1:0] grant;
    logic          cfg_wr_en;
    logic [2:0]    cfg_addr;
    logic [W-1:0]  cfg_wdata;
    logic [W-1:0]  cfg_rdata;
    logic [CH-1:0] next_grant;
    logic [W-1:0]  weight;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state
    logic [W-1:0] m_tab [CH];
    int           m_ptr;

    // Scoreboard queues for the registered outputs
    logic [CH-1:0] ng_q [$];
    logic [W-1:0]  rd_q [$];

    always #10 clk = ~clk;

    next_grant_precompute dut (
        .clk       (clk),
        .reset     (reset),
        .request   (request),
        .grant     (grant),
        .cfg_wr_en (cfg_wr_en),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .nextGrant (next_grant),
        .weight    (weight)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
    endtask

    function automatic int low_idx(input logic [CH-1:0] v);
        for (int i = 0; i < CH; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [CH-1:0] m_search(input logic [CH-1:0] req, input int p);
        logic [CH-1:0] oh;
        int j;
        oh = '0;
        for (int k = 0; k < CH; k++) begin
            j = (p + k) % CH;
            if (req[j] && (m_tab[j] != '0)) begin
                oh[j] = 1'b1;
                return oh;
            end
        end
        return oh;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) m_tab[i] = W'(DW);
        m_ptr = 0;
    endtask

    // One clock of stimulus: drive, check the combinational weight, queue
    // expectations for the registered outputs, clock, then pop and compare.
    task automatic step(input logic [CH-1:0] req, input logic [CH-1:0] gnt,
                        input logic wr, input logic [2:0] addr, input logic [W-1:0] wd);
        logic [W-1:0] exp_w;
        request   = req;
        grant     = gnt;
        cfg_wr_en = wr;
        cfg_addr  = addr;
        cfg_wdata = wd;
        #1;
        exp_w = (gnt != '0) ? m_tab[low_idx(gnt)] : '0;
        chk("weight", weight, exp_w);
        ng_q.push_back(m_search(req, m_ptr));
        rd_q.push_back(m_tab[addr]);
        if (gnt != '0) m_ptr = (low_idx(gnt) + 1) % CH;
        if (wr) m_tab[addr] = wd;
        @(posedge clk);
        #1;
        chk("nextGrant", W'(next_grant), W'(ng_q.pop_front()));
        chk("cfg_rdata", cfg_rdata, rd_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        request   = '0;
        grant     = '0;
        cfg_wr_en = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        model_reset();
        #3;
        chk("rst_nextGrant", W'(next_grant), '0);
        chk("rst_cfg_rdata", cfg_rdata, '0);
        chk("rst_weight", weight, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First candidate from ptr=0
        step(8'h05, 8'h00, 1'b0, 3'd0, '0);
        chk("tp_first", W'(next_grant), W'(8'h01));
        // grant ch0 -> ptr=1 -> ch2 wins two cycles later
        step(8'h05, 8'h01, 1'b0, 3'd0, '0);
        step(8'h05, 8'h00, 1'b0, 3'd0, '0);
        chk("tp_ptr1", W'(next_grant), W'(8'h04));
        // grant ch2 -> ptr=3 -> wrap back to ch0
        step(8'h05, 8'h04, 1'b0, 3'd0, '0);
        step(8'h05, 8'h00, 1'b0, 3'd0, '0);
        chk("tp_wrap", W'(next_grant), W'(8'h01));

        // grant ch7 wraps ptr to 0
        step(8'h80, 8'h80, 1'b0, 3'd0, '0);
        step(8'h80, 8'h00, 1'b0, 3'd0, '0);
        chk("tp_top_only", W'(next_grant), W'(8'h80));
        step(8'h81, 8'h80, 1'b0, 3'd0, '0);
        step(8'h81, 8'h00, 1'b0, 3'd0, '0);
        chk("tp_ptr_wrap0", W'(next_grant), W'(8'h01));

        // Weight write and immediate weight mux / read-back
        step(8'h00, 8'h00, 1'b1, 3'd2, 32'd5);
        step(8'h05, 8'h04, 1'b0, 3'd2, '0);
        chk("tp_weight5", weight, 32'd5);
        chk("tp_rdata5", cfg_rdata, 32'd5);

        // Zero weight disables a channel
        step(8'h00, 8'h00, 1'b1, 3'd0, 32'd0);
        step(8'h01, 8'h00, 1'b0, 3'd0, '0);
        chk("tp_disabled", W'(next_grant), W'(8'h00));
        step(8'h03, 8'h00, 1'b0, 3'd0, '0);
        chk("tp_skip_dis", W'(next_grant), W'(8'h02));

        // Write and search in the same cycle: search sees the old weight
        step(8'h02, 8'h00, 1'b1, 3'd1, 32'd0);
        step(8'h02, 8'h00, 1'b0, 3'd1, '0);
        step(8'h00, 8'h00, 1'b1, 3'd1, 32'd7);

        // Multi-hot grant resolves to the lowest bit (ch1 -> ptr=2)
        step(8'h0C, 8'h06, 1'b0, 3'd1, '0);
        step(8'h0C, 8'h00, 1'b0, 3'd3, '0);
        chk("tp_multihot", W'(next_grant), W'(8'h04));

        // Leave nextGrant=04 with ptr=3, then reset asynchronously
        step(8'h0C, 8'h04, 1'b0, 3'd2, '0);
        chk("pre_rst_ng", W'(next_grant), W'(8'h04));
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_nextGrant", W'(next_grant), '0);
        chk("arst_cfg_rdata", cfg_rdata, '0);
        for (int i = 0; i < CH; i++) begin
            grant = '0;
            grant[i] = 1'b1;
            #1;
            chk("arst_table", weight, W'(DW));
        end
        grant = '0;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ptr back at 0: ch1 must beat ch7
        step(8'h82, 8'h00, 1'b0, 3'd2, '0);
        chk("post_rst_ptr0", W'(next_grant), W'(8'h02));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_next_grant_precompute
